// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   fetch_entry_t : one prefetch FIFO entry {misaligned, pc, inst}
//   RST_PC / FETCH_DEPTH / NOP_INST : default reset PC, FIFO depth, NOP encoding
package inst_fetch_unit_pkg;

   localparam int unsigned INST_ADDR_W = 32;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned FETCH_DEPTH = 4;

   localparam logic [INST_ADDR_W-1:0] RST_PC   = 32'h0000_0000;
   localparam logic [INST_W-1:0]      NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic                   misaligned;
      logic [INST_ADDR_W-1:0] pc;
      logic [INST_W-1:0]      inst;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

   // A fetch target is legal only when word aligned.
   function automatic logic is_misaligned(input logic [INST_ADDR_W-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Generic synchronous FIFO used as the fetch prefetch buffer.
//   clk, rst       : clock, synchronous active-high reset
//   flush          : discard all entries (wins over push/pop)
//   push/push_data : enqueue; accepted when not full or popping the same cycle
//   pop            : dequeue head; ignored when empty
//   head_data      : current head entry (combinational read of registered storage)
//   full/empty/level : occupancy status
module fetch_fifo #(
   parameter int unsigned WIDTH = 65,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == LVL_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // Full plus a same-cycle pop still accepts the push.
   assign do_push = push & (~full | do_pop);

   assign head_data = mem[rd_ptr];
   assign level     = count;

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + LVL_W'(do_push) - LVL_W'(do_pop);
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, reads the combinational ROM,
// buffers {pc, inst} pairs and hands them to decode over valid/ready.
//   clk, rst                 : clock, synchronous active-high reset
//   rom_ce_o/rom_addr_o      : ROM enable (fetch enqueued this cycle) and fetch PC
//   rom_data_i               : ROM word for rom_addr_o, same cycle
//   redirect_i/redirect_pc_i : branch/jump/trap re-steer; flushes the buffer
//   id_valid_o/id_ready_i    : decode handshake for the head entry
//   id_pc_o/id_inst_o/id_misaligned_o : head entry payload
//   fifo_level_o             : number of entries presented to decode
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RST_PC,
   parameter int unsigned DEPTH    = FETCH_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     rom_ce_o,
   output logic [INST_ADDR_W-1:0]   rom_addr_o,
   input  logic [INST_W-1:0]        rom_data_i,
   input  logic                     redirect_i,
   input  logic [INST_ADDR_W-1:0]   redirect_pc_i,
   output logic                     id_valid_o,
   input  logic                     id_ready_i,
   output logic [INST_ADDR_W-1:0]   id_pc_o,
   output logic [INST_W-1:0]        id_inst_o,
   output logic                     id_misaligned_o,
   output logic [$clog2(DEPTH):0]   fifo_level_o
);

   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   // RUN: fetching; MARK: misaligned marker waiting for decode; HALT: marker consumed
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_MARK = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   fetch_state_t             state;
   fetch_state_t             state_n;
   logic [INST_ADDR_W-1:0]   pc;
   logic [INST_ADDR_W-1:0]   marker_pc;
   logic                     redirect_mis;
   logic                     marker_valid;
   logic                     deq;
   logic                     enq;
   fetch_entry_t             push_entry;
   fetch_entry_t             head_entry;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [LVL_W-1:0]         fifo_level;

   assign redirect_mis = is_misaligned(redirect_pc_i);
   assign marker_valid = (state == ST_MARK);

   assign id_valid_o = marker_valid | ~fifo_empty;
   assign deq        = id_valid_o & id_ready_i;
   assign enq        = ~rst & ~redirect_i & (state == ST_RUN) & (~fifo_full | deq);

   assign rom_ce_o   = enq;
   assign rom_addr_o = pc;

   // The marker only exists while the FIFO is empty, so it overlays the head.
   assign id_pc_o         = marker_valid ? marker_pc : head_entry.pc;
   assign id_inst_o       = marker_valid ? NOP_INST  : head_entry.inst;
   assign id_misaligned_o = marker_valid | (~fifo_empty & head_entry.misaligned);
   assign fifo_level_o    = fifo_level + LVL_W'(marker_valid);

   always_comb begin
      push_entry            = '0;
      push_entry.misaligned = 1'b0;
      push_entry.pc         = pc;
      push_entry.inst       = rom_data_i;
   end

   // Fetch state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_RUN;
      else     state <= state_n;
   end

   // Fetch next-state: redirects always win; a consumed marker parks the fetcher
   always_comb begin
      state_n = state;
      if (redirect_i) begin
         state_n = redirect_mis ? ST_MARK : ST_RUN;
      end else if (state == ST_MARK && id_ready_i) begin
         state_n = ST_HALT;
      end
   end

   // Fetch PC and misaligned marker address
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         marker_pc <= '0;
      end else if (redirect_i) begin
         if (redirect_mis) marker_pc <= redirect_pc_i;
         else              pc        <= redirect_pc_i;
      end else if (enq) begin
         pc <= pc + 32'd4;
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_i),
      .push      (enq),
      .push_data (push_entry),
      .pop       (deq),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: the driver pushes the expected
// accepted-instruction stream on every reset/redirect, the monitor pops on
// each decode handshake and also tracks occupancy/PC at the transaction level.
module tb_inst_fetch_unit;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_mis;
   logic [2:0]  fifo_level;

   int          checks   = 0;
   int          failures = 0;
   bit          mon_en   = 1'b0;

   exp_t        exp_q[$];
   logic [31:0] gen_pc;
   bit          stream_open;

   // Reference model state: where fetch is, how much is buffered, halted flag
   logic [31:0] pc_m;
   int          lvl_m;
   bit          halted_m;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h0000_0100 + (a >> 2);
   endfunction

   assign rom_data = rom_word(rom_addr);

   inst_fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rom_ce_o        (rom_ce),
      .rom_addr_o      (rom_addr),
      .rom_data_i      (rom_data),
      .redirect_i      (redirect),
      .redirect_pc_i   (redirect_pc),
      .id_valid_o      (id_valid),
      .id_ready_i      (id_ready),
      .id_pc_o         (id_pc),
      .id_inst_o       (id_inst),
      .id_misaligned_o (id_mis),
      .fifo_level_o    (fifo_level)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and record the stream decode should now see
   task automatic drive(input logic r, input logic rd, input logic [31:0] tgt, input logic rdy);
      @(posedge clk);
      #1;
      rst         = r;
      redirect    = rd;
      redirect_pc = tgt;
      id_ready    = rdy;
      if (r) begin
         exp_q.delete();
         gen_pc      = RESET_PC;
         stream_open = 1'b1;
      end else if (rd) begin
         exp_q.delete();
         if (tgt[1:0] == 2'b00) begin
            gen_pc      = tgt;
            stream_open = 1'b1;
         end else begin
            exp_q.push_back('{tgt, NOP, 1'b1});
            stream_open = 1'b0;
         end
      end
      while (stream_open && exp_q.size() < 8) begin
         exp_q.push_back('{gen_pc, rom_word(gen_pc), 1'b0});
         gen_pc = gen_pc + 32'd4;
      end
   endtask

   // Monitor: sample mid-cycle, compare, then advance the model across the edge
   always @(negedge clk) begin
      if (mon_en) begin
         bit   deq_m;
         bit   enq_m;
         exp_t e;
         deq_m = (lvl_m > 0) && id_ready;
         enq_m = !rst && !redirect && !halted_m && ((lvl_m < DEPTH) || deq_m);
         chk("rom_ce",   32'(rom_ce),     32'(enq_m));
         chk("rom_addr", rom_addr,        pc_m);
         chk("id_valid", 32'(id_valid),   32'(lvl_m > 0));
         chk("level",    32'(fifo_level), 32'(lvl_m));
         if (id_valid && id_ready && !rst && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL accept_unexpected: got pc %h expected no entry at %0t", id_pc, $time);
            end else begin
               e = exp_q.pop_front();
               chk("id_pc",   id_pc,       e.pc);
               chk("id_inst", id_inst,     e.inst);
               chk("id_mis",  32'(id_mis), 32'(e.mis));
            end
         end
         if (rst) begin
            pc_m     = RESET_PC;
            lvl_m    = 0;
            halted_m = 1'b0;
         end else if (redirect) begin
            if (redirect_pc[1:0] == 2'b00) begin
               pc_m     = redirect_pc;
               lvl_m    = 0;
               halted_m = 1'b0;
            end else begin
               lvl_m    = 1;
               halted_m = 1'b1;
            end
         end else begin
            lvl_m = lvl_m + int'(enq_m) - int'(deq_m);
            if (enq_m) pc_m = pc_m + 32'd4;
         end
      end
   end

   initial begin
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      id_ready    = 1'b0;
      pc_m        = RESET_PC;
      lvl_m       = 0;
      halted_m    = 1'b0;
      repeat (2) @(posedge clk);
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      mon_en = 1'b1;

      // Streaming from reset
      repeat (12) drive(1'b0, 1'b0, 32'h0, 1'b1);
      // Backpressure fills the buffer, then drains in order
      repeat (10) drive(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (8)  drive(1'b0, 1'b0, 32'h0, 1'b1);
      // Redirect while full and dequeuing
      repeat (6)  drive(1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b1, 32'h0000_0200, 1'b1);
      repeat (6)  drive(1'b0, 1'b0, 32'h0, 1'b1);
      // Misaligned redirect parks fetch until the next redirect
      drive(1'b0, 1'b1, 32'h0000_0202, 1'b0);
      repeat (3)  drive(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (3)  drive(1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 1'b1, 32'h0000_0300, 1'b1);
      repeat (6)  drive(1'b0, 1'b0, 32'h0, 1'b1);
      // PC wrap
      drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
      repeat (6)  drive(1'b0, 1'b0, 32'h0, 1'b1);
      // Reset mid-stream with entries buffered
      repeat (3)  drive(1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      repeat (6)  drive(1'b0, 1'b0, 32'h0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic        r;
         logic        rd;
         logic        rdy;
         logic [31:0] t;
         r   = ($urandom % 300) == 0;
         rd  = !r && (($urandom % 20) == 0);
         rdy = ($urandom % 4) != 0;
         case ($urandom % 8)
            0:       t = 32'hFFFF_FFF0 + 32'(($urandom % 4) * 4);
            1:       t = ($urandom & 32'hFFFF_FFFC) | 32'(1 + ($urandom % 3));
            default: t = $urandom & 32'h0000_FFFC;
         endcase
         drive(r, rd, t, rdy);
      end

      drive(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
